// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} memwait_state_t;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v == max_v) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: one E-stage operand's forwarding select, M result beats W result
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          fwd_o
);
  assign fwd_o = (reg_write_m_i && rd_m_i != '0 && rd_m_i == rs_i) ? FWD_M :
                 (reg_write_w_i && rd_w_i != '0 && rd_w_i == rs_i) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush, memory-wait freeze and perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              perf_clr,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic              MemReadM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  loaduse_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  fwd_sel_t fwd_a, fwd_b;
  logic lw_stall, mem_stall, run;
  logic [CNT_W-1:0] stall_q, flush_q, loaduse_q;
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i(Rs1E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(fwd_a)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i(Rs2E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(fwd_b)
  );
  assign lw_stall = ResultSrcE == RESULT_SRC_LOAD && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  generate
    if (MEM_WAIT > 0) begin : g_wait
      localparam int CW = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
      memwait_state_t state_q;
      logic [CW-1:0] cnt_q;
      assign mem_stall = (state_q == IDLE && MemReadM) || state_q == WAIT;
      // RELEASE always returns to IDLE so a held MemReadM cannot retrigger the same load
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            IDLE: if (MemReadM) begin
              state_q <= (MEM_WAIT == 1) ? RELEASE : WAIT;
              cnt_q   <= CW'((MEM_WAIT > 1) ? MEM_WAIT - 2 : 0);
            end
            WAIT: if (cnt_q == '0) state_q <= RELEASE; else cnt_q <= cnt_q - CW'(1);
            default: state_q <= IDLE;
          endcase
        end
    end else begin : g_nowait
      logic unused_mem_read;
      assign unused_mem_read = MemReadM;
      assign mem_stall = 1'b0;
    end
  endgenerate
  assign run       = ~reset;
  assign StallF    = run & (mem_stall | (lw_stall & ~PCSrcE));
  assign StallD    = StallF;
  assign StallE    = run & mem_stall;
  assign StallM    = StallE;
  assign FlushW    = StallE;
  assign FlushD    = run & ~mem_stall & PCSrcE;
  assign FlushE    = run & ~mem_stall & (lw_stall | PCSrcE);
  assign ForwardAE = run ? fwd_a : FWD_RF;
  assign ForwardBE = run ? fwd_b : FWD_RF;
  // saturating event counters; clear beats increment
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q   <= '0;
      flush_q   <= '0;
      loaduse_q <= '0;
    end else if (perf_clr) begin
      stall_q   <= '0;
      flush_q   <= '0;
      loaduse_q <= '0;
    end else begin
      if (StallF) stall_q <= CNT_W'(sat_inc(64'(stall_q), 64'(CNT_MAX)));
      if (FlushD) flush_q <= CNT_W'(sat_inc(64'(flush_q), 64'(CNT_MAX)));
      if (lw_stall & ~PCSrcE & ~mem_stall) loaduse_q <= CNT_W'(sat_inc(64'(loaduse_q), 64'(CNT_MAX)));
    end
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign loaduse_cnt = loaduse_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes, memory wait and counters
module tb_hazard_ctrl;
  logic clk = 1'b0, reset, perf_clr;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, MemReadM, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt, loaduse_cnt;
  logic StallF0, StallD0, StallE0, StallM0, FlushD0, FlushE0, FlushW0;
  logic [1:0] ForwardAE0, ForwardBE0;
  logic [31:0] stall_cnt0, flush_cnt0, loaduse_cnt0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.REG_AW(5), .MEM_WAIT(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .perf_clr(perf_clr), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .loaduse_cnt(loaduse_cnt)
  );
  hazard_ctrl dut0 (
    .clk(clk), .reset(reset), .perf_clr(perf_clr), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF0), .StallD(StallD0), .StallE(StallE0), .StallM(StallM0),
    .FlushD(FlushD0), .FlushE(FlushE0), .FlushW(FlushW0),
    .ForwardAE(ForwardAE0), .ForwardBE(ForwardBE0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .loaduse_cnt(loaduse_cnt0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_in();
    perf_clr = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; MemReadM = 0; RegWriteW = 0;
  endtask
  task automatic load_use();
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
  endtask
  initial begin
    clear_in();
    reset = 1; MemReadM = 1; PCSrcE = 1; RegWriteM = 1; RdM = 5; Rs1E = 5; load_use();
    #2;
    check("rst_stallf", StallF, 0);
    check("rst_stallm", StallM, 0);
    check("rst_flushw", FlushW, 0);
    check("rst_flushd", FlushD, 0);
    check("rst_flushe", FlushE, 0);
    check("rst_fwda", ForwardAE, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk); clear_in(); reset = 0;
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; #1;
    check("fwd_m", ForwardAE, 2'b10);
    RdM = 0; #1;
    check("fwd_w", ForwardAE, 2'b01);
    RegWriteW = 0; #1;
    check("fwd_rf", ForwardAE, 2'b00);
    RdM = 6; RegWriteM = 1; RegWriteW = 1; RdW = 6; Rs2E = 6; Rs1E = 3; #1;
    check("fwd_b_m", ForwardBE, 2'b10);
    check("fwd_a_none", ForwardAE, 2'b00);
    RegWriteM = 0; #1;
    check("fwd_b_w", ForwardBE, 2'b01);
    check("fwd0_b_w", ForwardBE0, 2'b01);
    @(negedge clk); clear_in();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushd", FlushD, 0);
    check("lu_stalle", StallE, 0);
    @(negedge clk);
    check("lu_cnt", loaduse_cnt, 1);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu0_cnt", loaduse_cnt0, 1);
    RdE = 0; #1;
    check("lu_rd0_stallf", StallF, 0);
    check("lu_rd0_flushe", FlushE, 0);
    @(negedge clk);
    check("lu_cnt_hold", loaduse_cnt, 1);
    clear_in(); load_use(); PCSrcE = 1; #1;
    check("br_flushd", FlushD, 1);
    check("br_flushe", FlushE, 1);
    check("br_stallf", StallF, 0);
    check("br_stalld", StallD, 0);
    @(negedge clk);
    check("br_flush_cnt", flush_cnt, 1);
    check("br_lu_cnt", loaduse_cnt, 1);
    check("br_stall_cnt", stall_cnt, 1);
    clear_in(); load_use(); perf_clr = 1;
    @(negedge clk);
    check("clr_pri_stall", stall_cnt, 0);
    check("clr_pri_flush", flush_cnt, 0);
    check("clr_pri_lu", loaduse_cnt, 0);
    clear_in();
    for (int i = 0; i < 8; i++) begin
      MemReadM = 1; #1;
      check($sformatf("mw_stallf_%0d", i), StallF, (i % 4) != 3);
      check($sformatf("mw_flushw_%0d", i), FlushW, (i % 4) != 3);
      check($sformatf("mw_stalle_%0d", i), StallE, (i % 4) != 3);
      if (i == 0) check("mw0_stallf", StallF0, 0);
      @(negedge clk);
    end
    MemReadM = 0; #1;
    check("mw_idle_stallf", StallF, 0);
    check("mw_stall_cnt", stall_cnt, 6);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      MemReadM = 1; PCSrcE = 1; #1;
      check($sformatf("mwbr_flushd_%0d", i), FlushD, i == 3);
      check($sformatf("mwbr_flushe_%0d", i), FlushE, i == 3);
      check($sformatf("mwbr_stallf_%0d", i), StallF, i != 3);
      @(negedge clk);
    end
    clear_in(); #1;
    check("mwbr_flush_cnt", flush_cnt, 1);
    check("mwbr_stall_cnt", stall_cnt, 9);
    @(negedge clk);
    MemReadM = 1;
    @(negedge clk);
    check("rw_wait_stallf", StallF, 1);
    reset = 1; #1;
    check("rw_stallf", StallF, 0);
    check("rw_flushw", FlushW, 0);
    check("rw_stall_cnt", stall_cnt, 0);
    check("rw_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    reset = 0; MemReadM = 0; #1;
    check("rw_idle_stallf", StallF, 0);
    @(negedge clk);
    load_use();
    repeat (20) @(negedge clk);
    clear_in(); #1;
    check("sat_stall_cnt", stall_cnt, 15);
    check("sat_lu_cnt", loaduse_cnt, 15);
    check("sat0_lu_cnt", loaduse_cnt0, 20);
    perf_clr = 1;
    @(negedge clk);
    check("clr_stall", stall_cnt, 0);
    check("clr_flush", flush_cnt, 0);
    check("clr_lu", loaduse_cnt, 0);
    check("clr0_lu", loaduse_cnt0, 0);
    perf_clr = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
